// File: rtl/arb_mux.sv
// Registered NUM-channel arbitrating multiplexer with valid/ready on every port.
// Fixed-priority or round-robin grant feeds a single output register stage.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int RR    = 1,
  parameter int SELW  = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM-1:0]       in_valid,
  input  logic [NUM*WIDTH-1:0] in_data,
  output logic [NUM-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  localparam int CW = SELW + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic             load;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [CW-1:0]    cand;
  logic [WIDTH-1:0] chan_data [NUM];

  for (genvar i = 0; i < NUM; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = !out_valid_q || out_ready;

  // Search order starts one past the last winner and wraps modulo NUM.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (RR != 0) begin
        cand = {1'b0, rr_ptr_q} + CW'(k + 1);
        if (cand >= CW'(NUM)) begin
          cand = cand - CW'(NUM);
        end
      end else begin
        cand = CW'(k);
      end
      if (!grant_found && in_valid[cand[SELW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    in_ready    = '0;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = chan_data[grant_idx];
        out_sel_d  = grant_idx;
        if (RR != 0) begin
          rr_ptr_d = grant_idx;
        end
        // A beat accepted on a reset edge would be lost, so no handshake then.
        in_ready[grant_idx] = resetn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SELW'(NUM - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: one fixed-priority and one round-robin instance
// share stimulus; a queue-based reference model predicts grants and beats.
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int NUM   = 4;
  localparam int SELW  = 2;

  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [NUM-1:0]       in_valid = '0;
  logic [NUM*WIDTH-1:0] in_data = '0;
  logic                 out_ready = 1'b0;

  // index 0: fixed priority, index 1: round-robin
  logic [NUM-1:0]   in_ready_w  [2];
  logic             out_valid_w [2];
  logic [WIDTH-1:0] out_data_w  [2];
  logic [SELW-1:0]  out_sel_w   [2];

  beat_t            exp_q [2][$];
  logic [WIDTH-1:0] chan_data [NUM];
  int               last_g = NUM - 1;
  int               checks = 0;
  int               errors = 0;

  arb_mux #(.WIDTH(WIDTH), .NUM(NUM), .RR(0)) dut_fp (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_data(out_data_w[0]),
    .out_sel(out_sel_w[0]), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(WIDTH), .NUM(NUM), .RR(1)) dut_rr (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_data(out_data_w[1]),
    .out_sel(out_sel_w[1]), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin: first requester after the last winner; fixed: lowest index.
  function automatic int exp_grant(input int policy, input logic [NUM-1:0] v, input int last);
    for (int off = 1; off <= NUM; off++) begin
      int ch;
      ch = (policy != 0) ? (last + off) % NUM : off - 1;
      if (v[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic model_cycle(input logic rst_edge);
    logic           load;
    int             g;
    logic [NUM-1:0] er;
    beat_t          b;
    for (int p = 0; p < 2; p++) begin
      if (rst_edge) begin
        chk(p != 0 ? "rr_rst_valid" : "fp_rst_valid", 64'(out_valid_w[p]), 64'd0);
        chk(p != 0 ? "rr_rst_data"  : "fp_rst_data",  64'(out_data_w[p]),  64'd0);
        chk(p != 0 ? "rr_rst_sel"   : "fp_rst_sel",   64'(out_sel_w[p]),   64'd0);
      end
      if (!resetn) begin
        chk(p != 0 ? "rr_rst_in_ready" : "fp_rst_in_ready", 64'(in_ready_w[p]), 64'd0);
        exp_q[p].delete();
      end else begin
        chk(p != 0 ? "rr_out_valid" : "fp_out_valid", 64'(out_valid_w[p]),
            64'(exp_q[p].size() != 0));
        load = (exp_q[p].size() == 0) || out_ready;
        g    = exp_grant(p, in_valid, last_g);
        er   = '0;
        if (load && g >= 0) er[g] = 1'b1;
        chk(p != 0 ? "rr_in_ready" : "fp_in_ready", 64'(in_ready_w[p]), 64'(er));
        if (load && g >= 0) begin
          b.sel  = SELW'(g);
          b.data = chan_data[g];
          exp_q[p].push_back(b);
          if (p == 1) last_g = g;
        end
      end
    end
    if (!resetn) last_g = NUM - 1;
  endtask

  task automatic step(input logic rst_n, input logic [NUM-1:0] v, input logic ordy);
    logic rst_edge;
    rst_edge = !resetn;
    @(posedge clk);
    #1;
    resetn    = rst_n;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < NUM; i++) in_data[i*WIDTH +: WIDTH] = chan_data[i];
    #1;
    model_cycle(rst_edge);
  endtask

  // Monitor: compares the presented beat every cycle, pops it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        for (int p = 0; p < 2; p++) begin
          if (out_valid_w[p] === 1'b1) begin
            if (exp_q[p].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL %s: got unexpected beat sel=%0h data=%0h required none",
                       p != 0 ? "rr_spurious" : "fp_spurious", out_sel_w[p], out_data_w[p]);
            end else begin
              chk(p != 0 ? "rr_data" : "fp_data", 64'(out_data_w[p]), 64'(exp_q[p][0].data));
              chk(p != 0 ? "rr_sel"  : "fp_sel",  64'(out_sel_w[p]),  64'(exp_q[p][0].sel));
              if (out_ready === 1'b1) void'(exp_q[p].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) chan_data[i] = $urandom;

    // reset held with all channels requesting
    repeat (3) step(1'b0, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);

    // round-robin rotation with no bubbles
    for (int i = 0; i < NUM; i++) chan_data[i] = 32'hA0 + i;
    repeat (8) step(1'b1, 4'b1111, 1'b1);

    // fixed priority: channel 1 dominates until it drops
    repeat (4) step(1'b1, 4'b1010, 1'b1);
    repeat (2) step(1'b1, 4'b1000, 1'b1);

    // backpressure with a known beat from channel 2
    for (int i = 0; i < NUM; i++) chan_data[i] = $urandom;
    chan_data[2] = 32'hDEADBEEF;
    step(1'b1, 4'b0100, 1'b1);
    chan_data[2] = $urandom;
    repeat (5) step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b0000, 1'b1);

    // sparse requests and pointer wrap
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    repeat (2) step(1'b1, 4'b1001, 1'b1);
    step(1'b1, 4'b0000, 1'b1);

    // reset during a stall discards the held beat
    step(1'b1, 4'b0010, 1'b1);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);

    // random traffic; non-requesting channels carry X data
    for (int n = 0; n < 400; n++) begin
      v = NUM'($urandom);
      for (int i = 0; i < NUM; i++) chan_data[i] = v[i] ? WIDTH'($urandom) : 'x;
      step(($urandom_range(0, 63) != 0), v, ($urandom_range(0, 3) != 0));
    end

    repeat (3) step(1'b1, 4'b0000, 1'b1);
    chk("fp_queue_drained", 64'(exp_q[0].size()), 64'd0);
    chk("rr_queue_drained", 64'(exp_q[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised successor to the combinational N-way select: registered NUM-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Selects one requesting channel per transfer by fixed-priority or round-robin policy. Registers the winner's data and index into a single output stage.
- Used to merge instruction-fetch, data and uncached requests onto one memory/bus port in the CPU.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM, 4, number of input channels; legal range 2..16.
- RR, 1, arbitration policy: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SELW, $clog2(NUM), width of the grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous active-low reset.
- in_valid  input  NUM  per-channel request.
- in_data  input  NUM*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM  per-channel accept; at most one bit high.
- out_valid  output  1  output register holds a transfer.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  SELW  registered index of the granted channel.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset, resetn=0 sampled at posedge: out_valid=0, out_data=0, out_sel=0, rr_ptr=NUM-1, so channel 0 has top priority after reset. in_ready is combinationally 0 while out_valid=0 and no in_valid is set.
- load = !out_valid | out_ready. The output stage can take a new transfer in any cycle where load=1, including a cycle where the current transfer drains.
- Grant (combinational):
  - RR=0: lowest index i with in_valid[i]=1.
  - RR=1: first i with in_valid[i]=1, searching from (rr_ptr+1) mod NUM upward and wrapping through NUM-1 to 0.
- in_ready[g] = load & in_valid[g] for the granted index g. All other in_ready bits are 0.
- in_ready depends only on in_valid, out_valid, out_ready and rr_ptr. It never depends on in_data.
- At posedge with load=1:
  - If any in_valid is set: out_valid<=1, out_data<=in_data[g], out_sel<=g. With RR=1, also rr_ptr<=g.
  - If no in_valid is set: out_valid<=0. out_data and out_sel hold their values.
- Stall: with out_valid=1 and out_ready=0, out_valid, out_data, out_sel and rr_ptr hold, and all in_ready bits are 0. Inputs must hold their request.
- Latency: 1 cycle from an input handshake to out_valid.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Fairness, RR=1: with all NUM channels continuously requesting, grants cycle 0,1,...,NUM-1,0. No channel waits more than NUM-1 transfers.
- rr_ptr advances only on an accepted transfer. Idle cycles and stalls do not move it.
- Wrap-around: rr_ptr=NUM-1 makes the search start at channel 0.
- Simultaneous events: drain and refill in the same cycle are legal. The old beat leaves, the new beat is registered, and out_valid stays 1 with no bubble.
- Reset mid-transfer: a pending out_valid=1 beat is discarded. Upstream must treat it as lost. No in_ready is asserted in the reset cycle, because the outputs take their reset values on that edge.
- Data outside the granted slice is don't-care. X on non-granted in_data must not propagate to out_data.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0 on every cycle. After release, the first grant is channel 0 (in_ready=4'b0001).
- Round-robin rotation, RR=1, NUM=4: in_valid=4'b1111 constant, out_ready=1, in_data[i]=32'hA0+i -> out_sel 0,1,2,3,0,1 on consecutive cycles, out_data 0xA0..0xA3 repeating, no bubbles.
- Fixed priority, RR=0: in_valid=4'b1010 held -> every grant goes to channel 1. Channel 3 is granted only after in_valid[1] drops, then out_sel=3, out_data=in_data[3].
- Backpressure: load 0xDEADBEEF from channel 2, then out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data=0xDEADBEEF and out_sel=2 stable, in_ready=0 throughout. When out_ready rises, channel 3 is granted next.
- Sparse and wrap, RR=1: rr_ptr=3 after a channel-3 grant, then in_valid=4'b0100 -> grant 2. Then in_valid=4'b1001 -> grant 3, then 0, matching the search order.
- Reset mid-stall: out_valid=1, out_ready=0, assert resetn=0 for 1 cycle -> out_valid=0 next cycle. With RR=1, the next grant restarts at channel 0.
